// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock sequencer on the free-running reference clock: pulses pll_rst,
// waits for a stable synchronized lock, then releases sys_rst; retries on timeout.
//
// state       | meaning
// S_RESET     | pll_rst held high for PLL_RST_CYCLES
// S_WAIT_LOCK | pll_rst low, waiting for lk, timeout counter running
// S_STABLE    | lk seen, counting consecutive lock cycles
// S_RUN       | system released, ready high
// S_FAULT     | retries exhausted, everything held in reset until rst
module pll_lock_supervisor #(
    parameter int SYNC_STAGES         = 2,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       lock_lost,
    output logic       fault,
    output logic [7:0] retry_cnt
);

    localparam int RST_W = (PLL_RST_CYCLES > 1)      ? $clog2(PLL_RST_CYCLES)      : 1;
    localparam int STB_W = (LOCK_STABLE_CYCLES > 1)  ? $clog2(LOCK_STABLE_CYCLES)  : 1;
    localparam int TMO_W = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;

    localparam logic [RST_W-1:0] RST_LAST = RST_W'(PLL_RST_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_RESET,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [RST_W-1:0]       rst_cnt_q, rst_cnt_d;
    logic [STB_W-1:0]       stb_cnt_q, stb_cnt_d;
    logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic [7:0]             retry_q, retry_d;
    logic [7:0]             retry_inc;
    logic                   pll_rst_q, pll_rst_d;
    logic                   sys_rst_q, sys_rst_d;
    logic                   ready_q, ready_d;
    logic                   lock_lost_q, lock_lost_d;
    logic                   fault_q, fault_d;
    logic                   lk;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], pll_locked};
    assign lk     = sync_q[SYNC_STAGES-1];

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q     <= S_RESET;
            sync_q      <= '0;
            rst_cnt_q   <= '0;
            stb_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            retry_q     <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            rst_cnt_q   <= rst_cnt_d;
            stb_cnt_q   <= stb_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            retry_q     <= retry_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_q   <= sys_rst_d;
            ready_q     <= ready_d;
            lock_lost_q <= lock_lost_d;
            fault_q     <= fault_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        stb_cnt_d = stb_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        retry_d   = retry_q;
        retry_inc = (retry_q == 8'hFF) ? 8'hFF : retry_q + 8'd1;
        case (state_q)
            S_RESET: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d   = S_WAIT_LOCK;
                    rst_cnt_d = '0;
                    tmo_cnt_d = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                end
            end
            S_WAIT_LOCK: begin
                // lock on the timeout cycle takes priority over the timeout
                if (lk) begin
                    state_d   = S_STABLE;
                    stb_cnt_d = '0;
                    tmo_cnt_d = '0;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    retry_d   = retry_inc;
                    tmo_cnt_d = '0;
                    if (MAX_RETRIES != 0 && int'(retry_inc) >= MAX_RETRIES) begin
                        state_d = S_FAULT;
                    end else begin
                        state_d   = S_RESET;
                        rst_cnt_d = '0;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            S_STABLE: begin
                if (!lk) begin
                    state_d   = S_WAIT_LOCK;
                    stb_cnt_d = '0;
                    tmo_cnt_d = '0;
                end else if (stb_cnt_q == STB_LAST) begin
                    state_d   = S_RUN;
                    stb_cnt_d = '0;
                    retry_d   = '0;
                end else begin
                    stb_cnt_d = stb_cnt_q + STB_W'(1);
                end
            end
            S_RUN: begin
                if (!lk) begin
                    state_d   = S_RESET;
                    rst_cnt_d = '0;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d   = S_RESET;
                rst_cnt_d = '0;
            end
        endcase
    end

    // outputs are decoded from the next state so they change on the transition edge
    always_comb begin
        pll_rst_d   = (state_d == S_RESET) || (state_d == S_FAULT);
        sys_rst_d   = (state_d != S_RUN);
        ready_d     = (state_d == S_RUN);
        fault_d     = (state_d == S_FAULT);
        lock_lost_d = (state_q == S_RUN) && (state_d != S_RUN);
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst   = sys_rst_q;
    assign ready     = ready_q;
    assign lock_lost = lock_lost_q;
    assign fault     = fault_q;
    assign retry_cnt = retry_q;

endmodule
